// File: rtl/regfile.sv
// rtl/regfile.sv - eight-entry register file with two registered read ports and one write-back port
module regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p2,
  input  logic              p5,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data_to_AR,
  output logic [DATA_W-1:0] data_to_BR,
  output logic              wb_done
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_commit;
  logic              byp_a;
  logic              byp_b;

  assign wr_commit = p5 & wb_en;
  // A capture coinciding with a commit to the same register must see the new value.
  assign byp_a     = wr_commit && (ra == wb_addr);
  assign byp_b     = wr_commit && (rb == wb_addr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      data_to_AR <= '0;
      data_to_BR <= '0;
      wb_done    <= 1'b0;
    end else begin
      if (wr_commit) begin
        regs[wb_addr] <= wb_data;
      end
      if (p2) begin
        data_to_AR <= byp_a ? wb_data : regs[ra];
        data_to_BR <= byp_b ? wb_data : regs[rb];
      end
      wb_done <= wr_commit;
    end
  end

endmodule
